// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers and fixed-latency busy/done handshake
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q;
  logic fin;
  logic [63:0] prod;
  logic na, nb;
  logic [31:0] ma, mb, dvs, uq, ur, quo, rem;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fin = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = op[1] ? DIV : MUL;
        cnt_n = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end else if (cnt == CW'(1)) begin
      fin = 1'b1;
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      cnt_n = cnt - CW'(1);
    end
  end
  // Low 64 bits of the product of sign-extended operands equal the signed product
  assign prod = op_q[0] ? {32'b0, a_q} * {32'b0, b_q}
                        : {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0
  assign na = ~op_q[0] & a_q[31];
  assign nb = ~op_q[0] & b_q[31];
  assign ma = na ? -a_q : a_q;
  assign mb = nb ? -b_q : b_q;
  assign dvs = mb == '0 ? 32'd1 : mb;
  assign uq = ma / dvs;
  assign ur = ma % dvs;
  assign quo = b_q == '0 ? '1 : (na ^ nb ? -uq : uq);
  assign rem = b_q == '0 ? a_q : (na ? -ur : ur);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done <= fin;
      if (state == IDLE && start) begin
        op_q <= op;
        a_q <= rs_data;
        b_q <= rt_data;
      end
      if (fin) begin
        hi <= op_q[1] ? rem : prod[63:32];
        lo <= op_q[1] ? quo : prod[31:0];
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= rs_data;
        if (lo_we) lo <= rs_data;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int vectors = 0, errs = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (o == 2'b00) return 64'(longint'(sa) * longint'(sb));
    if (o == 2'b01) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 2'b11) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic mt(input bit hw, input bit lw, input logic [31:0] v);
    @(negedge clk);
    hi_we = hw; lo_we = lw; rs_data = v;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi = v;
    if (lw) m_lo = v;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, input bit interfere, input bit lo_with_start);
    logic [63:0] r;
    int n, cnt;
    r = model(o, a, b);
    n = o[1] ? 10 : 5;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; lo_we = lo_with_start;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    if (scramble) begin rs_data = $urandom; rt_data = $urandom; end
    cnt = 0;
    while (busy && cnt < 40) begin
      if (cnt == 2 && interfere) begin
        start = 1'b1; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        hi_we = 1'b1; lo_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      chk("done_during_busy", 32'(done), 32'd0);
      chk("hold_hi", hi, m_hi);
      chk("hold_lo", lo, m_lo);
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk("busy_cycles", 32'(cnt), 32'(n));
    chk("done_pulse", 32'(done), 32'd1);
    chk("res_hi", hi, m_hi);
    chk("res_lo", lo, m_lo);
    @(posedge clk); #1;
    chk("done_fall", 32'(done), 32'd0);
    chk("after_hi", hi, m_hi);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    mt(1'b1, 1'b0, 32'h1234_5678);
    mt(1'b0, 1'b1, 32'h9ABC_DEF0);
    mt(1'b1, 1'b1, 32'h0F0F_0F0F);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    m_hi = '0; m_lo = '0;
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFFE);
    do_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("multu_hi_const", hi, 32'h00000001);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("div_lo_const", lo, 32'hFFFFFFFD);
    chk("div_hi_const", hi, 32'hFFFFFFFF);
    do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_lo_const", lo, 32'h80000000);
    do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("dz_hi_const", hi, 32'd5);
    do_op(2'b11, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
    do_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
    do_op(2'b11, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom_range(0, 7) == 0 ? 32'd0 : ($urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 20)) : $urandom);
      do_op(2'($urandom_range(0, 3)), a, b, 1'b1, i % 5 == 0, i % 7 == 0);
    end
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1; #1;
    m_hi = '0; m_lo = '0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
    end
    chk("midrst_hi_end", hi, 32'd0);
    chk("midrst_lo_end", lo, 32'd0);
    do_op(2'b01, 32'hCAFEBABE, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
